// File: rtl/bnn_stream_loader.sv
// Serial loader for a binary image and a bank of binary KxK filters.
// Each stream has its own input register, write counter and LOAD/FULL state.
module bnn_stream_loader #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int N_FILT = 8,
  parameter int K      = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    d_in_p,
  input  logic                    vld_p,
  input  logic                    d_in_w,
  input  logic                    vld_w,
  input  logic                    clr_p,
  input  logic                    clr_w,
  output logic [IMG_W*IMG_H-1:0]  pixels,
  output logic [N_FILT*K*K-1:0]   weights,
  output logic                    pix_done,
  output logic                    w_done,
  output logic                    load_done,
  output logic                    ovf
);

  localparam int PN  = IMG_W * IMG_H;
  localparam int WN  = N_FILT * K * K;
  localparam int PCW = (PN > 1) ? $clog2(PN) : 1;
  localparam int WCW = (WN > 1) ? $clog2(WN) : 1;

  typedef enum logic {LOAD = 1'b0, FULL = 1'b1} stream_state_t;

  logic           p_d_q, p_v_q;
  logic           w_d_q, w_v_q;
  logic [PCW-1:0] p_cnt;
  logic [WCW-1:0] w_cnt;
  stream_state_t  p_state, w_state;
  logic           p_ovf_hit, w_ovf_hit;

  // Pixel stream
  always_ff @(posedge clk) begin
    if (reset) begin
      p_d_q    <= 1'b0;
      p_v_q    <= 1'b0;
      pixels   <= '0;
      p_cnt    <= '0;
      pix_done <= 1'b0;
      p_state  <= LOAD;
    end else if (clr_p) begin
      p_d_q    <= 1'b0;
      p_v_q    <= 1'b0;
      pixels   <= '0;
      p_cnt    <= '0;
      pix_done <= 1'b0;
      p_state  <= LOAD;
    end else begin
      p_d_q <= d_in_p;
      p_v_q <= vld_p;
      if (p_v_q && p_state == LOAD) begin
        pixels[p_cnt] <= p_d_q;
        if (p_cnt == PCW'(PN - 1)) begin
          p_cnt    <= '0;
          pix_done <= 1'b1;
          p_state  <= FULL;
        end else begin
          p_cnt <= p_cnt + PCW'(1);
        end
      end
    end
  end

  // Weight stream
  always_ff @(posedge clk) begin
    if (reset) begin
      w_d_q   <= 1'b0;
      w_v_q   <= 1'b0;
      weights <= '0;
      w_cnt   <= '0;
      w_done  <= 1'b0;
      w_state <= LOAD;
    end else if (clr_w) begin
      w_d_q   <= 1'b0;
      w_v_q   <= 1'b0;
      weights <= '0;
      w_cnt   <= '0;
      w_done  <= 1'b0;
      w_state <= LOAD;
    end else begin
      w_d_q <= d_in_w;
      w_v_q <= vld_w;
      if (w_v_q && w_state == LOAD) begin
        weights[w_cnt] <= w_d_q;
        if (w_cnt == WCW'(WN - 1)) begin
          w_cnt   <= '0;
          w_done  <= 1'b1;
          w_state <= FULL;
        end else begin
          w_cnt <= w_cnt + WCW'(1);
        end
      end
    end
  end

  // A bit dropped by a simultaneous clear is not an overflow
  always_comb begin
    p_ovf_hit = p_v_q && (p_state == FULL) && !clr_p;
    w_ovf_hit = w_v_q && (w_state == FULL) && !clr_w;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (p_ovf_hit || w_ovf_hit) begin
      ovf <= 1'b1;
    end
  end

  assign load_done = pix_done & w_done;

endmodule

// File: doc/bnn_stream_loader.md
BNN_STREAM_LOADER -- requirements
Module: bnn_stream_loader

Interface
Parameters:
REQ-001 The block SHALL have parameter IMG_W, default 28, image columns.
REQ-002 The block SHALL have parameter IMG_H, default 28, image rows.
REQ-003 The block SHALL have parameter N_FILT, default 8, number of binary filters.
REQ-004 The block SHALL have parameter K, default 3, filter side length (K x K kernel).

Ports:
REQ-005 The block SHALL have `clk`, in, 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have `reset`, in, 1, synchronous active-high reset.
REQ-007 The block SHALL have `d_in_p`, in, 1, serial pixel bit.
REQ-008 The block SHALL have `vld_p`, in, 1, pixel bit valid strobe.
REQ-009 The block SHALL have `d_in_w`, in, 1, serial weight bit.
REQ-010 The block SHALL have `vld_w`, in, 1, weight bit valid strobe.
REQ-011 The block SHALL have `clr_p`, in, 1, restart pixel load and retain weights.
REQ-012 The block SHALL have `clr_w`, in, 1, restart weight load and retain pixels.
REQ-013 The block SHALL have `pixels`, out, IMG_W*IMG_H, flat image with bit index row*IMG_W+col.
REQ-014 The block SHALL have `weights`, out, N_FILT*K*K, flat weights with bit index f*K*K+r*K+c.
REQ-015 The block SHALL have `pix_done`, out, 1, image full.
REQ-016 The block SHALL have `w_done`, out, 1, weights full.
REQ-017 The block SHALL have `load_done`, out, 1, equal to pix_done AND w_done.
REQ-018 The block SHALL have `ovf`, out, 1, sticky flag: a valid bit arrived on a stream that was already full.

Function
REQ-019 Each stream SHALL pass through exactly one input register stage holding {data, valid} before storage is written.
REQ-020 A bit presented with its valid high before edge t SHALL be written to storage at edge t+1. Total latency is 2 edges from presentation to visible output.
REQ-021 The pixel and weight streams SHALL have independent write counters and SHALL be able to load concurrently, in any order, or interleaved.
REQ-022 The pixel counter SHALL be $clog2(IMG_W*IMG_H) bits wide. It SHALL start at 0 and increment by 1 per registered valid bit while pix_done is 0.
REQ-023 The weight counter SHALL be $clog2(N_FILT*K*K) bits wide and SHALL follow the same rule gated by w_done. Fill order is column, then row, then filter, each ascending.
REQ-024 Each stream SHALL have two states, LOAD and FULL. LOAD->FULL occurs on the edge that writes the last index (IMG_W*IMG_H-1 for pixels, N_FILT*K*K-1 for weights). On that edge the counter wraps to 0 and the stream's done flag goes to 1 in the same edge.
REQ-025 In FULL, a registered valid bit SHALL NOT modify storage, the counter, or the done flag. It SHALL set ovf to 1.
REQ-026 ovf SHALL remain 1 until reset. clr_p and clr_w SHALL NOT clear it.
REQ-027 When clr_x is high at an edge, that stream SHALL do all of the following: clear its storage to 0, clear its counter and done flag, flush its input register valid, and enter LOAD.
REQ-028 clr_x SHALL take priority over a simultaneous registered valid on the same stream; that bit is dropped.
REQ-029 A bit presented in the same cycle as clr_x SHALL be dropped.
REQ-030 clr_p SHALL leave weights, w_done and the weight counter untouched, and clr_w SHALL do the same for the pixel side.
REQ-031 vld low SHALL stall the stream with no state change. Gaps of any length between valid bits SHALL be tolerated.
REQ-032 load_done SHALL be combinational from the two registered done flags, with no added latency.

Reset
REQ-033 On reset high at an edge, the block SHALL set pixels, weights, both counters, both input registers, pix_done, w_done, load_done and ovf to 0, and both streams SHALL enter LOAD.
REQ-034 Reset SHALL override clr_p, clr_w and any valid bit.
REQ-035 Reset asserted mid-load SHALL discard partial data, and loading SHALL restart from index 0 after release.
REQ-036 Outputs SHALL hold their values without an input valid. No output SHALL depend on uninitialised state.

Verification
REQ-037 Scenario (defaults): 784 pixel bits of pattern i%3==0 and 72 weight bits alternating 1/0 -> pix_done rises 2 edges after bit 783; w_done rises 2 edges after bit 71; pixels[i]=(i%3==0); weights[j]=(j%2==0); load_done=1; ovf=0.
REQ-038 Scenario (IMG 4x4, N_FILT 2, K 3): random vld gaps with interleaved streams -> contents match the serial order exactly; load_done asserts only after both streams are full.
REQ-039 Scenario: 17th pixel bit on a 4x4 image after pix_done -> pixels unchanged, ovf=1, and ovf stays 1 through clr_p.
REQ-040 Scenario: with both streams full, pulse clr_p then load a new image -> pixels=0 and pix_done=0 the edge after clr_p; weights and w_done unchanged; the new image loads correctly.
REQ-041 Scenario: clr_w coincident with a valid weight bit at index 5 -> that bit is dropped; the next valid bit lands at index 0.
REQ-042 Scenario: reset asserted after 400 pixel bits, then a full reload -> all outputs are 0 after reset; the reload completes with correct contents at index 0..783.
